pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent PWM outputs (>=1).
REQ-002 Parameter WIDTH, default 8, width of counter, period and duty values.
REQ-003 Parameter PRESC_WIDTH, default 8, width of prescaler divide value.
REQ-004 Localparam CH_AW = max(1, ceil(log2(CHANNELS))), the channel address width.
REQ-005 clk_i  input  1  sole clock; all state on rising edge.
REQ-006 rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 en_i  input  1  global run enable.
REQ-008 center_i  input  1  mode select: 0 = edge-aligned, 1 = centre-aligned.
REQ-009 period_i  input  WIDTH  counter top value P.
REQ-010 prescale_i  input  PRESC_WIDTH  counter advances once every prescale_i+1 clocks.
REQ-011 wr_en_i  input  1  duty shadow write strobe.
REQ-012 wr_ch_i  input  CH_AW  channel index for the write.
REQ-013 wr_duty_i  input  WIDTH  duty value for the write.
REQ-014 invert_i  input  CHANNELS  per-channel output polarity, applied live.
REQ-015 pwm_o  output  CHANNELS  registered PWM outputs.
REQ-016 cycle_o  output  1  one-clock pulse marking the first clock of each PWM period.

Function
REQ-017 The prescaler counter SHALL count 0..prescale_q; "tick" is when it equals prescale_q, and it returns to 0 on that clock.
REQ-018 Edge mode: on each tick the main counter SHALL advance 0,1,..,P, then wrap to 0 (P+1 ticks per period).
REQ-019 Centre mode: on each tick the counter SHALL run 0 up to P, then down P-1..1, then 0 with direction up (2P ticks per period).
REQ-020 P = 0 in either mode: the counter SHALL stay at 0, and every tick is a boundary.
REQ-021 Boundary = the tick on which the counter returns to 0 (edge: cnt==P; centre: down and cnt==1).
REQ-022 At a boundary, the block SHALL load period_q, center_q and prescale_q from the inputs and load every active duty from its shadow.
REQ-023 The block SHALL ignore period_i, center_i and prescale_i changes between boundaries.
REQ-024 A write with wr_en_i=1 SHALL update shadow[wr_ch_i] on that clock edge.
REQ-025 The block SHALL ignore writes with wr_ch_i >= CHANNELS.
REQ-026 A write on the same clock as a boundary SHALL NOT reach the active duty until the next boundary; the boundary loads the pre-write shadow.
REQ-027 Raw output[k] SHALL be (cnt < duty_act[k]), compared unsigned at WIDTH bits.
REQ-028 duty 0 SHALL give a constant low output.
REQ-029 Edge mode: duty > P SHALL give a constant high output.
REQ-030 Centre mode: duty > P SHALL give a constant high output.
REQ-031 pwm_o[k] SHALL be registered: en_i ? raw[k] ^ invert_i[k] : invert_i[k]; latency is one clock from counter state.
REQ-032 cycle_o SHALL be a registered pulse, asserted when en_i=1, prescaler==0, cnt==0 and direction up, aligned with the pwm_o sample of the new period's first clock.
REQ-033 While en_i=0: prescaler and counter SHALL be held at 0 with direction up, cycle_o=0, configuration and active duties loaded every clock, and shadow writes still accepted.
REQ-034 On en_i rising, the first period SHALL start immediately with current values, and cycle_o SHALL be emitted on its first clock.

Reset
REQ-035 rst_n_i low SHALL immediately clear: prescaler, counter, direction (up), all shadow and active duties, period_q, prescale_q, center_q, pwm_o (all 0) and cycle_o (0).
REQ-036 Reset deassertion SHALL take effect on the next rising clk_i; the first cycle_o follows the first clock with en_i=1.
REQ-037 Reset asserted mid-period SHALL discard all pending shadow values.

Verification
REQ-038 Edge mode, WIDTH=8, prescale 0, P=9, ch0 duty 3 -> pwm_o[0] high 3 of every 10 clocks; cycle_o every 10 clocks, coincident with the first high clock.
REQ-039 Duty 0 / duty 10 with P=9 -> constant 0 / constant 1; toggling invert_i[k] inverts on the next clock.
REQ-040 Write duty 7 to ch0 mid-period -> current period keeps 3 high clocks and the next period has 7; a write on the boundary clock -> applied one period later.
REQ-041 Centre mode, P=4, prescale 1, duty 2 -> period 16 clocks, pwm high 6 consecutive clocks spanning the wrap; cycle_o every 16 clocks.
REQ-042 Change period_i 9->4 mid-period -> the current period completes at 10 clocks and the next is 5; wr_ch_i=5 with CHANNELS=4 -> no shadow changes.
REQ-043 rst_n_i pulsed low mid-period -> all outputs 0 asynchronously; en_i=0 -> pwm_o equals invert_i and cycle_o stays 0.

Source files
------------

// File: rtl/pwm_bank_if.sv
// Duty shadow write bus for pwm_bank: a strobe, a channel index and a duty value.
interface pwm_bank_if #(
  parameter int WIDTH = 8,
  parameter int CH_AW = 2
);
  logic             wr_en_i;
  logic [CH_AW-1:0] wr_ch_i;
  logic [WIDTH-1:0] wr_duty_i;

  modport master (output wr_en_i, wr_ch_i, wr_duty_i);
  modport slave  (input  wr_en_i, wr_ch_i, wr_duty_i);
endinterface

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one prescaled counter (edge- or centre-aligned).
// Configuration and duties are double-buffered and only swap at period boundaries.
module pwm_bank_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_duty_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             inv_i,
  output logic             pwm_o
);
  logic [WIDTH-1:0] shadow_q, duty_q;

  // The load samples the pre-write shadow, so a write on a boundary waits a period.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q <= '0;
      duty_q   <= '0;
      pwm_o    <= 1'b0;
    end else begin
      if (wr_i)   shadow_q <= wr_duty_i;
      if (load_i) duty_q   <= shadow_q;
      pwm_o <= en_i ? ((cnt_i < duty_q) ^ inv_i) : inv_i;
    end
  end
endmodule

module pwm_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 8,
  parameter int PRESC_WIDTH = 8,
  localparam int CH_AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   center_i,
  input  logic [WIDTH-1:0]       period_i,
  input  logic [PRESC_WIDTH-1:0] prescale_i,
  pwm_bank_if.slave              wr,
  input  logic [CHANNELS-1:0]    invert_i,
  output logic [CHANNELS-1:0]    pwm_o,
  output logic                   cycle_o
);
  logic [PRESC_WIDTH-1:0] presc_q, prescale_q;
  logic [WIDTH-1:0]       cnt_q, cnt_d, period_q;
  logic                   down_q, down_d, center_q;
  logic                   tick, bnd, load;

  assign tick = (presc_q == prescale_q);
  assign load = !en_i || (tick && bnd);

  // Next counter value for a tick; bnd flags the tick that returns it to 0.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    down_d = down_q;
    bnd    = 1'b0;
    if (!center_q) begin
      if (cnt_q == period_q) begin
        cnt_d = '0;
        bnd   = 1'b1;
      end
    end else if (down_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q <= WIDTH'(1)) begin
        cnt_d  = '0;
        down_d = 1'b0;
        bnd    = 1'b1;
      end
    end else if (cnt_q == period_q) begin
      // P of 0 or 1 has no down leg: the top is followed directly by 0.
      if (period_q <= WIDTH'(1)) begin
        cnt_d = '0;
        bnd   = 1'b1;
      end else begin
        cnt_d  = cnt_q - 1'b1;
        down_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q    <= '0;
      cnt_q      <= '0;
      down_q     <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      center_q   <= 1'b0;
      cycle_o    <= 1'b0;
    end else begin
      cycle_o <= en_i && (presc_q == '0) && (cnt_q == '0) && !down_q;
      if (!en_i) begin
        presc_q <= '0;
        cnt_q   <= '0;
        down_q  <= 1'b0;
      end else if (tick) begin
        presc_q <= '0;
        cnt_q   <= cnt_d;
        down_q  <= down_d;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      if (load) begin
        period_q   <= period_i;
        prescale_q <= prescale_i;
        center_q   <= center_i;
      end
    end
  end

  // Out-of-range channel indices match no lane and are dropped.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .wr_i      (wr.wr_en_i && (wr.wr_ch_i == CH_AW'(k))),
      .wr_duty_i (wr.wr_duty_i),
      .load_i    (load),
      .en_i      (en_i),
      .cnt_i     (cnt_q),
      .inv_i     (invert_i[k]),
      .pwm_o     (pwm_o[k])
    );
  end
endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: vector table, corner sequences and a
// phase-based reference model compared every clock under random stimulus.
module tb_pwm_bank;
  localparam int CH    = 3;
  localparam int W     = 8;
  localparam int PW    = 8;
  localparam int CH_AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, center = 1'b0;
  logic [W-1:0]  period = '0;
  logic [PW-1:0] prescale = '0;
  logic [CH-1:0] inv = '0;
  logic [CH-1:0] pwm_o;
  logic          cycle_o;

  int checks = 0;
  int errs   = 0;

  pwm_bank_if #(.WIDTH(W), .CH_AW(CH_AW)) wif ();

  pwm_bank #(.CHANNELS(CH), .WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .center_i(center),
    .period_i(period), .prescale_i(prescale), .wr(wif.slave),
    .invert_i(inv), .pwm_o(pwm_o), .cycle_o(cycle_o)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period as a phase index; the
  // counter value is derived from the phase (triangle for centre mode).
  int m_pc = 0, m_ph = 0, m_P = 0, m_ps = 0;
  bit m_ctr = 0;
  int m_sh[CH], m_act[CH];
  logic [CH-1:0] m_pwm = '0;
  logic m_cyc = 1'b0;
  int m_len, m_c;
  bit m_load;

  initial for (int k = 0; k < CH; k++) begin m_sh[k] = 0; m_act[k] = 0; end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_ph = 0; m_P = 0; m_ps = 0; m_ctr = 0;
      for (int k = 0; k < CH; k++) begin m_sh[k] = 0; m_act[k] = 0; end
      m_pwm = '0; m_cyc = 1'b0;
    end else begin
      m_len = m_ctr ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
      m_c   = (!m_ctr || m_ph <= m_P) ? m_ph : 2 * m_P - m_ph;
      for (int k = 0; k < CH; k++)
        m_pwm[k] = en ? ((m_c < m_act[k]) ^ inv[k]) : inv[k];
      m_cyc  = en && m_pc == 0 && m_ph == 0;
      m_load = 0;
      if (!en) begin
        m_pc = 0; m_ph = 0; m_load = 1;
      end else if (m_pc == m_ps) begin
        m_pc = 0; m_ph++;
        if (m_ph == m_len) begin m_ph = 0; m_load = 1; end
      end else m_pc++;
      if (m_load) begin
        m_P = int'(period); m_ps = int'(prescale); m_ctr = center;
        for (int k = 0; k < CH; k++) m_act[k] = m_sh[k];
      end
      if (wif.wr_en_i && int'(wif.wr_ch_i) < CH) m_sh[wif.wr_ch_i] = int'(wif.wr_duty_i);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (pwm_o !== m_pwm || cycle_o !== m_cyc) begin
        errs++;
        $display("FAIL model t=%0t: pwm=%b cyc=%b expected pwm=%b cyc=%b",
                 $time, pwm_o, cycle_o, m_pwm, m_cyc);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr_duty(input int ch, input int duty);
    wif.wr_en_i = 1'b1; wif.wr_ch_i = CH_AW'(ch); wif.wr_duty_i = W'(duty);
    @(negedge clk);
    wif.wr_en_i = 1'b0;
  endtask

  // One full period of channel ch, from one cycle_o to the next.
  task automatic measure(input int ch, output int len, output int hi);
    int n;
    len = 0; hi = 0; n = 0;
    while (!cycle_o && n < 2000) begin @(negedge clk); n++; end
    if (!cycle_o) begin
      errs++; $display("FAIL measure_start: no cycle_o within 2000 clocks");
      return;
    end
    len = 1; hi = int'(pwm_o[ch]); n = 0;
    forever begin
      @(negedge clk);
      if (cycle_o) break;
      len++; hi += int'(pwm_o[ch]); n++;
      if (n > 2000) begin
        errs++; $display("FAIL measure_end: period exceeds 2000 clocks");
        return;
      end
    end
  endtask

  task automatic setup(input bit c, input int p, input int ps, input int duty, input bit iv);
    @(negedge clk);
    en = 1'b0; center = c; period = W'(p); prescale = PW'(ps);
    wr_duty(0, duty);
    inv[0] = iv;
    repeat (2) @(negedge clk);
    en = 1'b1;
  endtask

  typedef struct {
    bit c; int p; int ps; int duty; bit iv; int exp_len; int exp_hi;
  } vec_t;
  vec_t tbl[8];

  int l, h;

  initial begin
    tbl[0] = '{0, 9, 0,  3, 0, 10, 3};
    tbl[1] = '{0, 9, 0,  0, 0, 10, 0};
    tbl[2] = '{0, 9, 0, 10, 0, 10, 10};
    tbl[3] = '{0, 9, 0,  3, 1, 10, 7};
    tbl[4] = '{1, 4, 1,  2, 0, 16, 6};
    tbl[5] = '{1, 4, 0,  5, 0,  8, 8};
    tbl[6] = '{0, 0, 2,  1, 0,  3, 3};
    tbl[7] = '{0, 4, 2,  2, 0, 15, 6};
    wif.wr_en_i = 1'b0; wif.wr_ch_i = '0; wif.wr_duty_i = '0;

    #1;
    chk("reset_pwm", int'(pwm_o), 0);
    chk("reset_cycle", int'(cycle_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      setup(tbl[i].c, tbl[i].p, tbl[i].ps, tbl[i].duty, tbl[i].iv);
      measure(0, l, h);
      chk($sformatf("vec%0d_len", i), l, tbl[i].exp_len);
      chk($sformatf("vec%0d_high", i), h, tbl[i].exp_hi);
    end

    // Mid-period duty write lands on the next period.
    setup(0, 9, 0, 3, 0);
    measure(0, l, h);
    fork
      measure(0, l, h);
      begin repeat (3) @(negedge clk); wr_duty(0, 7); end
    join
    chk("midwrite_cur_high", h, 3);
    measure(0, l, h);
    chk("midwrite_next_high", h, 7);

    // Write on the boundary clock is applied one period later.
    repeat (8) @(negedge clk);
    wr_duty(0, 2);
    measure(0, l, h);
    chk("bndwrite_next_high", h, 7);
    measure(0, l, h);
    chk("bndwrite_later_high", h, 2);

    // Period change mid-period waits for the boundary.
    fork
      measure(0, l, h);
      begin repeat (4) @(negedge clk); period = W'(4); end
    join
    chk("perchg_cur_len", l, 10);
    measure(0, l, h);
    chk("perchg_next_len", l, 5);
    period = W'(9);
    measure(0, l, h);

    // Out-of-range channel write is ignored.
    wr_duty(2, 5);
    wr_duty(3, 1);
    measure(2, l, h);
    measure(2, l, h);
    chk("badch_ch2_high", h, 5);

    // Disabled: output follows invert, no cycle pulse.
    @(negedge clk);
    en = 1'b0; inv = 3'b101;
    repeat (2) @(negedge clk);
    chk("dis_pwm_inv", int'(pwm_o), 5);
    chk("dis_cycle", int'(cycle_o), 0);
    inv = 3'b010;
    @(negedge clk);
    chk("dis_inv_toggle", int'(pwm_o), 2);
    inv = '0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      wif.wr_en_i = ($urandom_range(3) == 0);
      wif.wr_ch_i = CH_AW'($urandom_range(3));
      wif.wr_duty_i = W'($urandom_range(14));
      if ($urandom_range(7) == 0) inv = CH'($urandom);
      if ($urandom_range(19) == 0) period = W'($urandom_range(12));
      if ($urandom_range(29) == 0) center = $urandom_range(1) == 1;
      if ($urandom_range(29) == 0) prescale = PW'($urandom_range(3));
      en = ($urandom_range(199) == 0) ? ~en : en;
      if (!en && $urandom_range(9) == 0) en = 1'b1;
    end
    wif.wr_en_i = 1'b0;

    // Async reset mid-period clears outputs and pending shadows.
    setup(0, 9, 0, 2, 0);
    inv = 3'b111;
    measure(0, l, h);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pwm", int'(pwm_o), 0);
    chk("arst_cycle", int'(cycle_o), 0);
    @(negedge clk);
    rst_n = 1'b1; inv = '0;
    measure(0, l, h);
    measure(0, l, h);
    chk("arst_len", l, 10);
    chk("arst_high", h, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
